// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin front end that shares one FPU between two requesters.
// Loads are sequenced as enable then enable+ld. Computes hold enable until the FPU
// reports done. Illegal opcodes are answered immediately with the invalid flag.
// Optional EXEC watchdog: define FPU_ARB_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module fpu_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [4:0]       req0_a1,
    input  logic [4:0]       req0_a2,
    input  logic [4:0]       req0_a3,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [4:0]       req1_a1,
    input  logic [4:0]       req1_a2,
    input  logic [4:0]       req1_a3,
    input  logic [WIDTH-1:0] req1_data,
    output logic             fpu_enable,
    output logic             fpu_ld,
    output logic [2:0]       fpu_opcode,
    output logic [4:0]       fpu_addr1,
    output logic [4:0]       fpu_addr2,
    output logic [4:0]       fpu_addr3,
    output logic [WIDTH-1:0] fpu_inp,
    input  logic             fpu_done,
    input  logic [WIDTH-1:0] fpu_out,
    input  logic [4:0]       fpu_flags,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [4:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LD_EN, LD_PULSE, EXEC, RESP} state_e;
    localparam logic [2:0] OP_LOAD = 3'b100;

    state_e           state_q, state_d;
    logic             last_q, last_d;     // index granted most recently
    logic             gnt_q, gnt_d;       // index of the in-flight request
    logic [2:0]       op_q, op_d;
    logic [4:0]       a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
    logic [WIDTH-1:0] inp_q, inp_d;
    logic             rid_q, rid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [4:0]       rflags_q, rflags_d;
    logic             take, pick1, enter_resp, tmo_hit;
    logic [2:0]       sel_op;

    // Grant selection: req1 wins when alone, or on a tie when req0 was served last
    always_comb begin
        pick1      = req1_valid & (~req0_valid | ~last_q);
        take       = (state_q == IDLE) & ~rstp & (req0_valid | req1_valid);
        req0_ready = take & ~pick1;
        req1_ready = take & pick1;
        sel_op     = pick1 ? req1_op : req0_op;
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rto_q, rto_d;

    // Watchdog: counts EXEC cycles; done on the terminal cycle takes priority
    always_comb begin
        tmo_hit   = (state_q == EXEC) & ~fpu_done & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = (state_q == EXEC) ? tmo_cnt_q + CW'(1) : '0;
        rto_d     = enter_resp ? tmo_hit : rto_q;
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            tmo_cnt_q <= '0;
            rto_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rto_q     <= rto_d;
        end
    end
    assign rsp_timeout = rto_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (sel_op == OP_LOAD)  state_d = LD_EN;
                    else if (!sel_op[2])    state_d = EXEC;
                    else                    state_d = RESP;
                end
            end
            LD_EN:    state_d = LD_PULSE;
            LD_PULSE: state_d = RESP;
            EXEC:     if (fpu_done || tmo_hit) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        fpu_enable = (state_q == LD_EN) | (state_q == LD_PULSE) | (state_q == EXEC);
        fpu_ld     = (state_q == LD_PULSE);
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    // Datapath next values: request latch on accept, response capture on entry to RESP
    always_comb begin
        last_d     = last_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        a1_d       = a1_q;
        a2_d       = a2_q;
        a3_d       = a3_q;
        inp_d      = inp_q;
        enter_resp = (state_d == RESP) & (state_q != RESP);
        if (take) begin
            last_d = pick1;
            gnt_d  = pick1;
            // illegal ops never touch the FPU drive lines
            if (sel_op <= OP_LOAD) begin
                op_d  = sel_op;
                a1_d  = pick1 ? req1_a1   : req0_a1;
                a2_d  = pick1 ? req1_a2   : req0_a2;
                a3_d  = pick1 ? req1_a3   : req0_a3;
                inp_d = pick1 ? req1_data : req0_data;
            end
        end
        rid_d    = enter_resp ? gnt_d : rid_q;
        rdata_d  = rdata_q;
        rflags_d = rflags_q;
        if (enter_resp) begin
            rdata_d  = '0;
            rflags_d = '0;
            if (state_q == EXEC && fpu_done) begin
                rdata_d  = fpu_out;
                rflags_d = fpu_flags;
            end else if (state_q == IDLE) begin
                rflags_d = 5'b00100;  // only illegal ops go IDLE->RESP
            end
        end
    end

    // Datapath registers; last_q resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            op_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
            inp_q    <= '0;
            rid_q    <= 1'b0;
            rdata_q  <= '0;
            rflags_q <= '0;
        end else begin
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            a3_q     <= a3_d;
            inp_q    <= inp_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rflags_q <= rflags_d;
        end
    end

    assign fpu_opcode = op_q;
    assign fpu_addr1  = a1_q;
    assign fpu_addr2  = a2_q;
    assign fpu_addr3  = a3_q;
    assign fpu_inp    = inp_q;
    assign rsp_id     = rid_q;
    assign rsp_data   = rdata_q;
    assign rsp_flags  = rflags_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed bench with a transaction-level reference model.
module tb_fpu_arbiter;
    localparam int W   = 32;
    localparam int TMO = 16;

    logic clk = 1'b0, rstp = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [4:0] req0_a1 = '0, req0_a2 = '0, req0_a3 = '0;
    logic [4:0] req1_a1 = '0, req1_a2 = '0, req1_a3 = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic fpu_enable, fpu_ld, fpu_done;
    logic [2:0] fpu_opcode;
    logic [4:0] fpu_addr1, fpu_addr2, fpu_addr3;
    logic [W-1:0] fpu_inp;
    logic [W-1:0] fpu_out = '0;
    logic [4:0] fpu_flags = '0;
    logic rsp_valid, rsp_id, rsp_timeout, busy;
    logic [W-1:0] rsp_data;
    logic [4:0] rsp_flags;

    fpu_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstp(rstp),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a1(req0_a1), .req0_a2(req0_a2), .req0_a3(req0_a3), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a1(req1_a1), .req1_a2(req1_a2), .req1_a3(req1_a3), .req1_data(req1_data),
        .fpu_enable(fpu_enable), .fpu_ld(fpu_ld), .fpu_opcode(fpu_opcode),
        .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3), .fpu_inp(fpu_inp),
        .fpu_done(fpu_done), .fpu_out(fpu_out), .fpu_flags(fpu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // FPU stand-in: raises done on the done_at-th consecutive compute-enable cycle
    int done_at = 0;
    int fpu_cnt = 0;
    always @(posedge clk) fpu_cnt <= (fpu_enable && fpu_opcode < 3'd4) ? fpu_cnt + 1 : 0;
    assign fpu_done = (done_at > 0) && fpu_enable && (fpu_opcode < 3'd4) && (fpu_cnt == done_at - 1);

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked by age since accept.
    // kind: 0 load, 1 compute, 2 illegal. rsp_at = age of the response cycle (-1 unknown).
    bit m_idle = 1, m_last = 1, m_gid = 0;
    int m_kind = 0, m_age = 0, m_rsp_at = -1;
    logic [2:0] m_fop = 0;
    logic [4:0] m_fa1 = 0, m_fa2 = 0, m_fa3 = 0;
    logic [W-1:0] m_finp = 0;
    logic m_rid = 0, m_rto = 0, p_to = 0;
    logic [W-1:0] m_rdata = 0, p_data = 0;
    logic [4:0] m_rflags = 0, p_flags = 0;

    initial begin : model
        bit g;
        logic [2:0] op;
        int a;
        forever begin
            @(posedge clk or posedge rstp);
            if (rstp) begin
                m_idle = 1; m_last = 1; m_age = 0; m_rsp_at = -1;
                m_fop = 0; m_fa1 = 0; m_fa2 = 0; m_fa3 = 0; m_finp = 0;
                m_rid = 0; m_rdata = 0; m_rflags = 0; m_rto = 0;
            end else if (m_idle) begin
                if (req0_valid || req1_valid) begin
                    g = req1_valid && (!req0_valid || !m_last);
                    m_last = g; m_gid = g; m_idle = 0; m_age = 1; m_rsp_at = -1;
                    op = g ? req1_op : req0_op;
                    p_data = 0; p_flags = 0; p_to = 0;
                    if (op == 3'b100) begin m_kind = 0; m_rsp_at = 3; end
                    else if (op < 3'b100) m_kind = 1;
                    else begin m_kind = 2; m_rsp_at = 1; p_flags = 5'b00100; end
                    if (op <= 3'b100) begin
                        m_fop = op;
                        m_fa1 = g ? req1_a1 : req0_a1;
                        m_fa2 = g ? req1_a2 : req0_a2;
                        m_fa3 = g ? req1_a3 : req0_a3;
                        m_finp = g ? req1_data : req0_data;
                    end
                    if (m_age == m_rsp_at) begin m_rid = m_gid; m_rdata = p_data; m_rflags = p_flags; m_rto = p_to; end
                end
            end else begin
                a = m_age;
                if (a == m_rsp_at) m_idle = 1;
                else begin
                    if (m_kind == 1 && m_rsp_at < 0) begin
                        if (fpu_done) begin m_rsp_at = a + 1; p_data = fpu_out; p_flags = fpu_flags; p_to = 0; end
`ifdef FPU_ARB_TIMEOUT_EN
                        else if (a == TMO) begin m_rsp_at = a + 1; p_data = 0; p_flags = 0; p_to = 1; end
`endif
                    end
                    m_age = a + 1;
                    if (m_age == m_rsp_at) begin m_rid = m_gid; m_rdata = p_data; m_rflags = p_flags; m_rto = p_to; end
                end
            end
        end
    end

    // Per-cycle comparison against the model; also logs observed grants
    int gq[$];
    initial begin : compare
        logic e_r0, e_r1, e_en, e_ld, e_rv;
        forever begin
            @(negedge clk);
            e_r0 = !rstp && m_idle && req0_valid && (!req1_valid || m_last);
            e_r1 = !rstp && m_idle && req1_valid && (!req0_valid || !m_last);
            e_en = !m_idle && ((m_kind == 0 && m_age <= 2) || (m_kind == 1 && m_rsp_at < 0));
            e_ld = !m_idle && m_kind == 0 && m_age == 2;
            e_rv = !m_idle && m_age == m_rsp_at;
            chk("m_ready0", 32'(req0_ready), 32'(e_r0));
            chk("m_ready1", 32'(req1_ready), 32'(e_r1));
            chk("m_busy", 32'(busy), 32'(!m_idle));
            chk("m_enable", 32'(fpu_enable), 32'(e_en));
            chk("m_ld", 32'(fpu_ld), 32'(e_ld));
            chk("m_opcode", 32'(fpu_opcode), 32'(m_fop));
            chk("m_addrs", {17'b0, fpu_addr1, fpu_addr2, fpu_addr3}, {17'b0, m_fa1, m_fa2, m_fa3});
            chk("m_inp", fpu_inp, m_finp);
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("m_rsp_id", 32'(rsp_id), 32'(m_rid));
            chk("m_rsp_data", rsp_data, m_rdata);
            chk("m_rsp_flags", 32'(rsp_flags), 32'(m_rflags));
            chk("m_rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
        end
    end

    // Present one request, hold until accepted (bounded); returns just after the accept edge
    task automatic issue(input bit id, input logic [2:0] op, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic [W-1:0] d);
        bit got = 0;
        if (id) begin req1_op = op; req1_a1 = a1; req1_a2 = a2; req1_a3 = a3; req1_data = d; req1_valid = 1; end
        else    begin req0_op = op; req0_a1 = a1; req0_a2 = a2; req0_a3 = a3; req0_data = d; req0_valid = 1; end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
    endtask

    // Both requesters valid together until each is accepted once
    task automatic both_round(input logic [2:0] op);
        bit g0, g1;
        req0_op = op; req1_op = op; req0_data = 32'h11; req1_data = 32'h22;
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 100 && (req0_valid || req1_valid); k++) begin
            @(negedge clk); g0 = req0_ready; g1 = req1_ready;
            @(posedge clk); #1;
            if (g0) req0_valid = 0;
            if (g1) req1_valid = 0;
        end
        chk("rr_wait", 32'(req0_valid | req1_valid), 32'd0);
        req0_valid = 0; req1_valid = 0;
    endtask

    // Compute request: count enable cycles until the response, then check it
    task automatic run_comp(input bit id, input logic [2:0] op, input int dat, input int exp_en,
                            input logic exp_to, input logic [W-1:0] exp_d, input logic [4:0] exp_f);
        int en_n = 0;
        bit seen = 0;
        done_at = dat;
        issue(id, op, 5'd1, 5'd2, 5'd3, 32'hA5A5_0000);
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
            else if (fpu_enable) en_n++;
        end
        chk("comp_rsp_seen", 32'(seen), 32'd1);
        chk("comp_en_cycles", 32'(en_n), 32'(exp_en));
        chk("comp_rsp_id", 32'(rsp_id), 32'(id));
        chk("comp_rsp_data", rsp_data, exp_d);
        chk("comp_rsp_flags", 32'(rsp_flags), 32'(exp_f));
        chk("comp_rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_g[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int rv_n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        rstp = 0;

        // round robin: four simultaneous rounds of loads
        for (int r = 0; r < 4; r++) both_round(3'b100);
        chk("rr_count", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(exp_g[i]));

        // load on req0: enable/ld sequence and 3-cycle latency
        issue(0, 3'b100, 5'd0, 5'd0, 5'd0, 32'h3F8C_CCCD);
        @(negedge clk);
        chk("ld1_en", 32'(fpu_enable), 32'd1); chk("ld1_ld", 32'(fpu_ld), 32'd0);
        chk("ld1_inp", fpu_inp, 32'h3F8C_CCCD);
        @(negedge clk);
        chk("ld2_en", 32'(fpu_enable), 32'd1); chk("ld2_ld", 32'(fpu_ld), 32'd1);
        @(negedge clk);
        chk("ld3_rv", 32'(rsp_valid), 32'd1); chk("ld3_id", 32'(rsp_id), 32'd0);
        chk("ld3_en", 32'(fpu_enable), 32'd0); chk("ld3_data", rsp_data, 32'd0);
        @(negedge clk);
        chk("ld4_rv", 32'(rsp_valid), 32'd0); chk("ld4_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // compute on req1 with done after 7 cycles
        fpu_out = 32'h43A0_CCCD; fpu_flags = 5'b00001;
        run_comp(1, 3'b010, 7, 7, 1'b0, 32'h43A0_CCCD, 5'b00001);

        // illegal op on req0
        issue(0, 3'b110, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ill_rv", 32'(rsp_valid), 32'd1); chk("ill_en", 32'(fpu_enable), 32'd0);
        chk("ill_flags", 32'(rsp_flags), 32'h4); chk("ill_data", rsp_data, 32'd0);
        chk("ill_opcode_held", 32'(fpu_opcode), 32'h2);
        @(posedge clk); #1;

`ifdef FPU_ARB_TIMEOUT_EN
        run_comp(0, 3'b000, 0, 16, 1'b1, 32'd0, 5'd0);
        run_comp(0, 3'b000, 16, 16, 1'b0, 32'h43A0_CCCD, 5'b00001);
`else
        run_comp(0, 3'b000, 30, 30, 1'b0, 32'h43A0_CCCD, 5'b00001);
`endif

        // reset during EXEC: immediate clear, no response, then normal service
        done_at = 0;
        issue(0, 3'b001, 5'd4, 5'd5, 5'd6, 32'h1234_5678);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rstp = 1; #1;
        chk("rst_en", 32'(fpu_enable), 32'd0); chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0); chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_opcode", 32'(fpu_opcode), 32'd0); chk("rst_inp", fpu_inp, 32'd0);
        rv_n = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) rv_n++; end
        @(posedge clk); #1; rstp = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid) rv_n++; end
        chk("rst_no_rsp", 32'(rv_n), 32'd0);
        @(posedge clk); #1;
        issue(1, 3'b100, 5'd7, 5'd0, 5'd0, 32'hCAFE_F00D);
        repeat (3) @(negedge clk);
        chk("post_rst_rv", 32'(rsp_valid), 32'd1); chk("post_rst_id", 32'(rsp_id), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
